// File: rtl/dq_burst_ctrl_pkg.sv
// Shared types and defaults for the DQ burst sequencer.
package ddr_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAT   = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } burst_state_t;

    localparam logic SEL_WRITE = 1'b1;
    localparam logic SEL_READ  = 1'b0;

    localparam int DEF_WL  = 4;
    localparam int DEF_RL  = 6;
    localparam int DEF_GAP = 2;

    // One counter serves latency, burst and gap, so it must hold the largest of them (max 15).
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/dq_burst_ctrl_if.sv
// Command handshake plus SerDes-side signals of the DQ burst sequencer.
interface dq_burst_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_rd;
    logic [WIDTH-1:0] cmd_wdata;
    logic             cmd_ready;
    logic             SerDes_en;
    logic             SerDes_Sel;
    logic [WIDTH-1:0] ser_wdata;
    logic [WIDTH-1:0] des_rdata;
    logic             wr_done;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    // Front-end and SerDes side.
    modport master (
        output cmd_valid, cmd_rd, cmd_wdata, des_rdata,
        input  cmd_ready, SerDes_en, SerDes_Sel, ser_wdata, wr_done, rd_valid, rd_data
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_rd, cmd_wdata, des_rdata,
        output cmd_ready, SerDes_en, SerDes_Sel, ser_wdata, wr_done, rd_valid, rd_data
    );
endinterface

// File: rtl/dq_burst_ctrl.sv
// Sequences one read/write burst on the DQ SerDes array: latency wait, BL-cycle burst, turnaround gap.
// Latency: SerDes_en rises L edges after accept; done pulse after L+BL; cmd_ready back after L+BL+GAP.
// Backpressure: cmd_ready low while busy; cmd_valid offered then is ignored, never queued.
module dq_burst_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int arch  = 16,
    parameter int BL    = WIDTH / arch,
    parameter int WL    = DEF_WL,
    parameter int RL    = DEF_RL,
    parameter int GAP   = DEF_GAP
) (
    input  logic           mem_clk,
    input  logic           rst_n,
    dq_burst_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL - 1);
    localparam logic [CNT_W-1:0] RL_LD  = CNT_W'(RL - 1);
    localparam logic [CNT_W-1:0] BL_LD  = CNT_W'(BL - 1);
    localparam logic [CNT_W-1:0] GAP_LD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ready_q, ready_d;
    logic             en_q, en_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic accept;
    logic cnt_zero;
    logic burst_end;

    assign accept    = (state_q == S_IDLE) && ready_q && bus.cmd_valid;
    assign cnt_zero  = (cnt_q == '0);
    assign burst_end = (state_q == S_BURST) && cnt_zero;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            en_q       <= 1'b0;
            sel_q      <= SEL_READ;
            wdata_q    <= '0;
            wr_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            en_q       <= en_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            wr_done_q  <= wr_done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LAT;
                    cnt_d   = bus.cmd_rd ? RL_LD : WL_LD;
                end
            end
            S_LAT: begin
                if (cnt_zero) begin
                    state_d = S_BURST;
                    cnt_d   = BL_LD;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            S_BURST: begin
                if (cnt_zero) begin
                    // A zero gap skips the turnaround state entirely.
                    state_d = (GAP == 0) ? S_IDLE : S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        ready_d    = (state_d == S_IDLE);
        en_d       = (state_d == S_BURST);
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        wr_done_d  = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (accept) begin
            sel_d = bus.cmd_rd ? SEL_READ : SEL_WRITE;
            if (!bus.cmd_rd) begin
                wdata_d = bus.cmd_wdata;
            end
        end
        if (burst_end) begin
            wr_done_d  = (sel_q == SEL_WRITE);
            rd_valid_d = (sel_q == SEL_READ);
            if (sel_q == SEL_READ) begin
                rd_data_d = bus.des_rdata;
            end
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.SerDes_en  = en_q;
    assign bus.SerDes_Sel = sel_q;
    assign bus.ser_wdata  = wdata_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;

endmodule

// File: doc/dq_burst_ctrl.md
# dq_burst_ctrl

Burst sequencer for the DQ serializer/deserializer array. Accepts one read or write command at a time from the controller front-end over a valid/ready handshake. Applies the programmed write or read latency, then holds `SerDes_en` for exactly one burst of `BL` memory-clock cycles with `SerDes_Sel` set for direction. Returns a write-done pulse or the captured read word, and enforces a bus-turnaround gap before the next command.

## Interface
- `WIDTH`, 32: data word width on both the command and the SerDes side.
- `arch`, 16: DQ pin count.
- `BL`, `WIDTH/arch`: burst length in `mem_clk` cycles.
- `WL`, 4: write latency, in cycles from accept to first burst cycle; legal range 1..15.
- `RL`, 6: read latency, in cycles from accept to first burst cycle; legal range 1..15.
- `GAP`, 2: idle cycles after each burst before `cmd_ready` rises; legal range 0..7.

Ports:
- `mem_clk` in 1: the only clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_rd` in 1: 1 = read, 0 = write. Qualified by `cmd_valid`.
- `cmd_wdata` in WIDTH: write word. Qualified by `cmd_valid && !cmd_rd`.
- `cmd_ready` out 1: controller is idle and can accept a command.
- `SerDes_en` out 1: burst active. Drives the SerDes array.
- `SerDes_Sel` out 1: 1 = serialize/drive DQ, 0 = deserialize/receive.
- `ser_wdata` out WIDTH: registered write word presented to the SerDes.
- `des_rdata` in WIDTH: deserialized word from the SerDes.
- `wr_done` out 1: one-cycle pulse when a write burst completes.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is valid.
- `rd_data` out WIDTH: captured read word.

## Operation
States:
- **IDLE**: `cmd_ready`=1. Accepts a command on an edge where `cmd_valid && cmd_ready`. Goes to LAT.
- **LAT**: counts down the latency.
- **BURST**: `SerDes_en`=1 for `BL` cycles.
- **GAP**: counts down `GAP` cycles, then returns to IDLE.

At the accept edge:
- `cnt` is loaded with `(cmd_rd ? RL : WL) - 1`.
- `dir` is latched and `SerDes_Sel` is set to `!cmd_rd`.
- For a write, `ser_wdata` is loaded with `cmd_wdata`. For a read, `ser_wdata` holds its value.
- `cmd_ready` is cleared.

State transitions and counters:
- In LAT, `cnt` decrements each edge. At the edge where `cnt`==0, the state goes to BURST, `cnt` is loaded with `BL-1`, and `SerDes_en` is set to 1.
- In BURST, `cnt` decrements each edge. At the edge where `cnt`==0:
  - `SerDes_en` is cleared.
  - A write pulses `wr_done`.
  - A read pulses `rd_valid` and loads `rd_data` with `des_rdata` sampled at that edge.
  - The state goes to GAP with `cnt`=`GAP-1`, or directly to IDLE if `GAP`==0, setting `cmd_ready`.
- In GAP, at the edge where `cnt`==0, the state goes to IDLE and `cmd_ready` is set.

Output behaviour:
- `SerDes_Sel` holds its last value while idle. It changes only at an accept edge.
- `ser_wdata` and `rd_data` hold their values between commands.
- `cmd_valid` while `cmd_ready`=0 is ignored. No command is queued or dropped-and-flagged.
- All outputs are registered. `cmd_ready` is registered, not derived from `cmd_valid`.

Counter sizing:
- `cnt` is 4 bits wide, sized to the largest of `WL`, `RL`, `BL`, and `GAP`.
- Decrement is unsigned and never wraps, because every load is ≥ 0 and the state leaves on `cnt`==0.

## Timing
Reset values (while `rst_n`=0 and immediately on assertion):
- State is IDLE.
- `cmd_ready`=0, `SerDes_en`=0, `SerDes_Sel`=0 (receive, so DQ is not driven).
- `wr_done`=0, `rd_valid`=0, `ser_wdata`=0, `rd_data`=0.
- `cmd_ready` rises at the first edge after `rst_n` deasserts.

Burst timing, for an accept at edge `k` with `L` = `WL` or `RL`:
- `SerDes_en` is high from edge `k+L` to edge `k+L+BL`.
- The done pulse is high for one cycle after edge `k+L+BL`.
- `cmd_ready` rises at edge `k+L+BL+GAP`.
- The minimum command period is `L+BL+GAP+1` edges.
- `SerDes_Sel` is stable for `L` cycles before `SerDes_en` rises, which provides direction turnaround.

Reset mid-operation: the burst aborts immediately, no done pulse is generated, and all outputs take their reset values.

## Structure
- Shared package `ddr_ctrl_pkg`:
  - State encoding `burst_state_t` = {IDLE, LAT, BURST, GAP}.
  - Constants `SEL_WRITE`=1 and `SEL_READ`=0.
  - Default `WL`, `RL`, and `GAP` values.
- Single module, no sub-modules. The down-counter is inline.
- Instantiated beside the SerDes top. `SerDes_en`, `SerDes_Sel`, `ser_wdata`, and `des_rdata` connect 1:1 to it.

## Test plan
All scenarios use `WIDTH`=32, `arch`=16, `BL`=2, `WL`=4, `RL`=6, `GAP`=2.
- **Reset:** `rst_n` low → all outputs 0. First edge after release → `cmd_ready`=1.
- **Write:** write `cmd_wdata`=0xDEADBEEF accepted at edge 0 →
  - `ser_wdata`=0xDEADBEEF and `SerDes_Sel`=1 after edge 0.
  - `SerDes_en`=1 after edges 4–5.
  - `wr_done` high one cycle after edge 6.
  - `cmd_ready`=1 after edge 8.
- **Read:** read accepted at edge 0, model drives `des_rdata`=0x12345678 at edge 8 →
  - `SerDes_Sel`=0; `SerDes_en` high after edges 6–7.
  - `rd_valid`=1 with `rd_data`=0x12345678 after edge 8.
  - `ser_wdata` unchanged.
- **Back-to-back:** write then read with `cmd_valid` held high →
  - Second accept exactly 9 edges after the first.
  - `SerDes_Sel` flips 1→0 at the second accept edge, 6 cycles before `SerDes_en` rises.
  - No overlapping bursts.
- **Ignored request:** `cmd_valid` pulsed while busy → no state change, no extra burst.
- **Mid-burst reset:** `rst_n` asserted at edge 5 of a write → `SerDes_en`=0 immediately, no `wr_done`, `cmd_ready`=1 one edge after release.
